rx_frame_parser: RTL and testbench



---
 rtl/rx_eth_pkg.sv | 33 +++
 rtl/rx_frame_parser.sv | 269 ++++++++++++++++++++++++++
 tb/tb_rx_frame_parser.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_eth_pkg.sv
// Shared state type, Ethernet header constants and helpers for rx_frame_parser.
package rx_eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } rx_state_e;

    localparam int unsigned ETH_HDR_WORDS = 7;
    localparam int unsigned ETH_HDR_BYTES = 14;
    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam int unsigned REM_W         = 16;

    // Number of 16-bit FIFO words holding a frame of len bytes (rounded up).
    function automatic logic [REM_W-1:0] frame_words(input logic [15:0] len);
        return (len >> 1) + {15'd0, len[0]};
    endfunction

    // 16-bit slice idx (0 = most significant) of a MAC address.
    function automatic logic [15:0] mac_word(input logic [47:0] mac, input logic [2:0] idx);
        logic [15:0] w;
        case (idx)
            3'd0:    w = mac[47:32];
            3'd1:    w = mac[31:16];
            3'd2:    w = mac[15:0];
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rx_frame_parser.sv
// Pops length-prefixed Ethernet frames from a show-ahead FIFO, filters on MAC/EtherType
// and streams payload words out. Optional counters enabled by `define RX_FRAME_STATS_EN.
module rx_frame_parser
    import rx_eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR        = 48'h0001_0203_0405,
    parameter logic [15:0] ETHERTYPE       = 16'h88B5,
    parameter int unsigned MAX_FRAME_BYTES = 1518
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_odd,
    output logic [47:0] src_mac,
    output logic        frame_drop
`ifdef RX_FRAME_STATS_EN
    ,
    output logic [15:0] stat_accepted,
    output logic [15:0] stat_dropped
`endif
);

    rx_state_e        state_q,      state_d;
    logic [REM_W-1:0] rem_q,        rem_d;
    logic [2:0]       hdr_cnt_q,    hdr_cnt_d;
    logic             len_odd_q,    len_odd_d;
    logic             dst_miss_q,   dst_miss_d;
    logic             bcast_miss_q, bcast_miss_d;
    logic             first_q,      first_d;
    logic [47:0]      src_shadow_q, src_shadow_d;
    logic [47:0]      src_mac_q,    src_mac_d;
    logic [15:0]      out_data_q,   out_data_d;
    logic             out_valid_q,  out_valid_d;
    logic             out_sop_q,    out_sop_d;
    logic             out_eop_q,    out_eop_d;
    logic             out_odd_q,    out_odd_d;
    logic             frame_drop_q, frame_drop_d;

    logic pop_s;
    logic len_pop_s;
    logic out_accept_s;

    assign out_accept_s = out_valid_q & out_ready;

    // Next-state, FIFO pop and output-register load logic.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        hdr_cnt_d    = hdr_cnt_q;
        len_odd_d    = len_odd_q;
        dst_miss_d   = dst_miss_q;
        bcast_miss_d = bcast_miss_q;
        first_d      = first_q;
        src_shadow_d = src_shadow_q;
        src_mac_d    = src_mac_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_sop_d    = out_sop_q;
        out_eop_d    = out_eop_q;
        out_odd_d    = out_odd_q;
        frame_drop_d = 1'b0;
        pop_s        = 1'b0;
        len_pop_s    = 1'b0;

        if (out_accept_s) begin
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
            out_odd_d   = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                len_pop_s = ~fifo_empty;
            end

            ST_HDR: begin
                if (!fifo_empty) begin
                    pop_s     = 1'b1;
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                    case (hdr_cnt_q)
                        3'd0, 3'd1, 3'd2: begin
                            if (fifo_q != mac_word(MAC_ADDR, hdr_cnt_q)) begin
                                dst_miss_d = 1'b1;
                            end else begin
                                dst_miss_d = dst_miss_q;
                            end
                            if (fifo_q != mac_word(BROADCAST_MAC, hdr_cnt_q)) begin
                                bcast_miss_d = 1'b1;
                            end else begin
                                bcast_miss_d = bcast_miss_q;
                            end
                        end
                        3'd3: src_shadow_d[47:32] = fifo_q;
                        3'd4: src_shadow_d[31:16] = fifo_q;
                        3'd5: src_shadow_d[15:0]  = fifo_q;
                        3'd6: begin
                            hdr_cnt_d = 3'd0;
                            rem_d     = rem_q - REM_W'(ETH_HDR_WORDS);
                            // Either the station or the broadcast comparison must have survived all three words.
                            if ((!dst_miss_q || !bcast_miss_q) && (fifo_q == ETHERTYPE)) begin
                                state_d   = ST_PAYLOAD;
                                src_mac_d = src_shadow_q;
                                first_d   = 1'b1;
                            end else begin
                                state_d      = ST_DROP;
                                frame_drop_d = 1'b1;
                            end
                        end
                        default: hdr_cnt_d = 3'd0;
                    endcase
                end else begin
                    pop_s = 1'b0;
                end
            end

            ST_PAYLOAD: begin
                if (rem_q != '0) begin
                    if (!fifo_empty && (!out_valid_q || out_ready)) begin
                        pop_s       = 1'b1;
                        rem_d       = rem_q - 16'd1;
                        out_data_d  = fifo_q;
                        out_valid_d = 1'b1;
                        out_sop_d   = first_q;
                        out_eop_d   = (rem_q == 16'd1);
                        out_odd_d   = (rem_q == 16'd1) & len_odd_q;
                        first_d     = 1'b0;
                    end else begin
                        pop_s = 1'b0;
                    end
                end else if (out_accept_s) begin
                    // The eop word leaves now; a waiting length word may be taken in the same cycle.
                    state_d   = ST_IDLE;
                    len_pop_s = ~fifo_empty;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end

            ST_DROP: begin
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                end else if (!fifo_empty) begin
                    pop_s = 1'b1;
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (len_pop_s) begin
            pop_s        = 1'b1;
            len_odd_d    = fifo_q[0];
            rem_d        = frame_words(fifo_q);
            hdr_cnt_d    = 3'd0;
            dst_miss_d   = 1'b0;
            bcast_miss_d = 1'b0;
            if (fifo_q == 16'd0) begin
                state_d = ST_IDLE;
            end else if ((fifo_q <= 16'(ETH_HDR_BYTES)) || (fifo_q > 16'(MAX_FRAME_BYTES))) begin
                state_d      = ST_DROP;
                frame_drop_d = 1'b1;
            end else begin
                state_d = ST_HDR;
            end
        end else begin
            len_odd_d = len_odd_d;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            hdr_cnt_q    <= 3'd0;
            len_odd_q    <= 1'b0;
            dst_miss_q   <= 1'b0;
            bcast_miss_q <= 1'b0;
            first_q      <= 1'b0;
            src_shadow_q <= 48'h0;
            src_mac_q    <= 48'h0;
            out_data_q   <= 16'h0000;
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_odd_q    <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            hdr_cnt_q    <= hdr_cnt_d;
            len_odd_q    <= len_odd_d;
            dst_miss_q   <= dst_miss_d;
            bcast_miss_q <= bcast_miss_d;
            first_q      <= first_d;
            src_shadow_q <= src_shadow_d;
            src_mac_q    <= src_mac_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            out_odd_q    <= out_odd_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    assign fifo_rdreq = pop_s;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_sop    = out_sop_q;
    assign out_eop    = out_eop_q;
    assign out_odd    = out_odd_q;
    assign src_mac    = src_mac_q;
    assign frame_drop = frame_drop_q;

`ifdef RX_FRAME_STATS_EN
    logic [15:0] stat_acc_q, stat_acc_d;
    logic [15:0] stat_drp_q, stat_drp_d;

    // Saturating frame counters.
    always_comb begin
        stat_acc_d = stat_acc_q;
        stat_drp_d = stat_drp_q;
        if (out_accept_s && out_eop_q && (stat_acc_q != 16'hFFFF)) begin
            stat_acc_d = stat_acc_q + 16'd1;
        end else begin
            stat_acc_d = stat_acc_q;
        end
        if (frame_drop_q && (stat_drp_q != 16'hFFFF)) begin
            stat_drp_d = stat_drp_q + 16'd1;
        end else begin
            stat_drp_d = stat_drp_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_acc_q <= 16'h0000;
            stat_drp_q <= 16'h0000;
        end else begin
            stat_acc_q <= stat_acc_d;
            stat_drp_q <= stat_drp_d;
        end
    end

    assign stat_accepted = stat_acc_q;
    assign stat_dropped  = stat_drp_q;
`endif

endmodule

// File: tb/tb_rx_frame_parser.sv
// Scoreboard bench for rx_frame_parser: a FIFO model feeds directed frames, a monitor checks outputs.
module tb_rx_frame_parser;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic        out_odd;
    logic [47:0] src_mac;
    logic        frame_drop;
`ifdef RX_FRAME_STATS_EN
    logic [15:0] stat_accepted;
    logic [15:0] stat_dropped;
`endif

    rx_frame_parser dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_odd    (out_odd),
        .src_mac    (src_mac),
        .frame_drop (frame_drop)
`ifdef RX_FRAME_STATS_EN
        ,
        .stat_accepted (stat_accepted),
        .stat_dropped  (stat_dropped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        sop;
        logic        eop;
        logic        odd;
        logic [47:0] mac;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] fmem[$];
    logic [15:0] body[$];
    int          total = 0;
    int          bad = 0;
    int          drop_pulses = 0;
    int          cyc = 0;
    bit          rd_pend = 1'b0;
    bit          gap_en = 1'b0;
    bit          ready_toggle = 1'b0;
    bit          ready_hold = 1'b1;
    bit          hold_pend = 1'b0;
    logic [18:0] held;

    localparam logic [47:0] STA = 48'h0001_0203_0405;
    localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC = 48'hAABB_CCDD_EEFF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model: pops at the clock edge, presents next word shortly after.
    initial begin
        fifo_q     = 16'h0000;
        fifo_empty = 1'b1;
        out_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rd_pend && fmem.size() != 0) void'(fmem.pop_front());
            fifo_empty = (fmem.size() == 0) || (gap_en && (cyc % 3 == 1));
            fifo_q     = (fmem.size() != 0) ? fmem[0] : 16'h0000;
            out_ready  = ready_toggle ? cyc[0] : ready_hold;
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks hold and pop legality.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            rd_pend = fifo_rdreq && !fifo_empty;
            if (fifo_rdreq) check("rdreq_nonempty", fifo_empty, 1'b0);
            if (frame_drop) drop_pulses++;
            if (!reset_n) hold_pend = 1'b0;
            if (hold_pend) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", {out_data, out_sop, out_eop, out_odd}, held);
            end
            hold_pend = reset_n && out_valid && !out_ready;
            held      = {out_data, out_sop, out_eop, out_odd};
            if (reset_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_flags", {out_sop, out_eop, out_odd}, {e.sop, e.eop, e.odd});
                    check("src_mac", src_mac, e.mac);
                end
            end
        end
    end

    task automatic add_hdr(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et);
        body.push_back(dst[47:32]);
        body.push_back(dst[31:16]);
        body.push_back(dst[15:0]);
        body.push_back(src[47:32]);
        body.push_back(src[31:16]);
        body.push_back(src[15:0]);
        body.push_back(et);
    endtask

    // Queue length word plus body; accepted frames push their payload expectations.
    task automatic push_frame(input logic [15:0] len, input bit acc, input bit odd, input logic [47:0] src);
        exp_t e;
        fmem.push_back(len);
        foreach (body[i]) fmem.push_back(body[i]);
        if (acc) begin
            for (int i = 7; i < body.size(); i++) begin
                e.data = body[i];
                e.sop  = (i == 7);
                e.eop  = (i == body.size() - 1);
                e.odd  = (i == body.size() - 1) && odd;
                e.mac  = src;
                sb.push_back(e);
            end
        end
        body.delete();
    endtask

    task automatic run_and_check(input string name, input int exp_drops, input int budget);
        int n  = 0;
        int d0 = drop_pulses;
        while ((fmem.size() != 0 || sb.size() != 0 || out_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d cycles expected under %0d", name, n, budget);
        end
        repeat (4) @(negedge clk);
        check({name, "_drops"}, drop_pulses - d0, exp_drops);
        check({name, "_leftover"}, sb.size(), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_flags", {out_sop, out_eop, out_odd, frame_drop}, 4'b0000);
        check("rst_data", out_data, 16'h0000);
        check("rst_src_mac", src_mac, 48'h0);
        check("rst_rdreq", fifo_rdreq, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // L=20 to the station address, three even payload words.
        add_hdr(STA, SRC, 16'h88B5);
        body.push_back(16'h1111); body.push_back(16'h2222); body.push_back(16'h3333);
        push_frame(16'd20, 1'b1, 1'b0, SRC);
        run_and_check("unicast", 0, 200);

        // L=19 broadcast: odd last word.
        add_hdr(BC, 48'h1020_3040_5060, 16'h88B5);
        body.push_back(16'h4444); body.push_back(16'h5555); body.push_back(16'h6600);
        push_frame(16'd19, 1'b1, 1'b1, 48'h1020_3040_5060);
        run_and_check("broadcast", 0, 200);

        // L=64 wrong destination: 32 words drained.
        add_hdr(48'h0001_0203_0406, SRC, 16'h88B5);
        for (int i = 0; i < 25; i++) body.push_back(16'(i));
        push_frame(16'd64, 1'b0, 1'b0, SRC);
        run_and_check("dst_miss", 1, 200);

        // L=2000 oversize: 1000 words drained, then a normal frame.
        for (int i = 0; i < 1000; i++) body.push_back(16'hC000 + 16'(i));
        push_frame(16'd2000, 1'b0, 1'b0, SRC);
        add_hdr(STA, 48'h0A0B_0C0D_0E0F, 16'h88B5);
        body.push_back(16'h7777); body.push_back(16'h8888); body.push_back(16'h9999);
        push_frame(16'd20, 1'b1, 1'b0, 48'h0A0B_0C0D_0E0F);
        run_and_check("oversize", 1, 3000);

        // Ready toggling and FIFO gaps on an L=26 frame.
        gap_en = 1'b1;
        ready_toggle = 1'b1;
        add_hdr(STA, SRC, 16'h88B5);
        for (int i = 1; i <= 6; i++) body.push_back(16'hA000 + 16'(i));
        push_frame(16'd26, 1'b1, 1'b0, SRC);
        run_and_check("stall", 0, 400);
        gap_en = 1'b0;
        ready_toggle = 1'b0;

        // Boundaries: L=0 skipped, L=14 dropped, L=15 single odd word, wrong EtherType dropped.
        fmem.push_back(16'd0);
        add_hdr(STA, SRC, 16'h88B5);
        push_frame(16'd14, 1'b0, 1'b0, SRC);
        add_hdr(STA, 48'h1111_2222_3333, 16'h88B5);
        body.push_back(16'hBE00);
        push_frame(16'd15, 1'b1, 1'b1, 48'h1111_2222_3333);
        add_hdr(STA, SRC, 16'h0800);
        body.push_back(16'h1234); body.push_back(16'h5678); body.push_back(16'h9ABC);
        push_frame(16'd20, 1'b0, 1'b0, SRC);
        run_and_check("bounds", 2, 300);

`ifdef RX_FRAME_STATS_EN
        check("stat_accepted", stat_accepted, 16'd5);
        check("stat_dropped", stat_dropped, 16'd4);
`endif

        // Reset while a payload word is held by a stalled consumer.
        ready_hold = 1'b0;
        add_hdr(STA, SRC, 16'h88B5);
        body.push_back(16'hD001); body.push_back(16'hD002); body.push_back(16'hD003);
        push_frame(16'd20, 1'b0, 1'b0, SRC);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_valid", out_valid, 1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_flags", {out_sop, out_eop, out_odd}, 3'b000);
        check("async_rst_src", src_mac, 48'h0);
`ifdef RX_FRAME_STATS_EN
        check("rst_stat_accepted", stat_accepted, 16'd0);
        check("rst_stat_dropped", stat_dropped, 16'd0);
`endif
        fmem.delete();
        sb.delete();
        ready_hold = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Parser restarts cleanly from IDLE.
        add_hdr(BC, 48'h5555_6666_7777, 16'h88B5);
        body.push_back(16'hEE00);
        push_frame(16'd15, 1'b1, 1'b1, 48'h5555_6666_7777);
        run_and_check("after_reset", 0, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
